// File: rtl/jt12_regwr.sv
`default_nettype none
// ============================================================================
// Module   : jt12_regwr
// Brief    : CPU-side write decoder for the FM register file. Latches the
//            address phase, decodes data writes into held din/ch/op plus a
//            one-hot update strobe that stays up for one full slot revolution.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_regwr #(
    parameter int num_ch = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [7:0]  cpu_din,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_wr,
    output logic        busy,
    output logic [7:0]  din,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic [10:0] up,
    output logic [5:0]  latch_fnum,
    output logic        effect,
    output logic        csm,
    output logic [10:0] fnum_ch3op1,
    output logic [10:0] fnum_ch3op2,
    output logic [10:0] fnum_ch3op3,
    output logic [2:0]  block_ch3op1,
    output logic [2:0]  block_ch3op2,
    output logic [2:0]  block_ch3op3
);

    localparam logic [4:0] c_last      = 5'(4 * num_ch - 1);
    localparam bit         c_two_parts = (num_ch == 6);

    logic [7:0]  r_sel;
    logic        r_part;
    logic [4:0]  r_cnt;
    logic [5:0]  r_ch3_latch;

    logic        w_data_ok;
    logic [10:0] w_up;
    logic        w_mode;
    logic        w_latch;
    logic        w_ch3hi;
    logic        w_ch3lo;

    assign w_data_ok = cpu_wr & cpu_addr[0] & ~busy & (~r_part | c_two_parts);

    always_comb begin
        w_up    = '0;
        w_mode  = 1'b0;
        w_latch = 1'b0;
        w_ch3hi = 1'b0;
        w_ch3lo = 1'b0;
        if (w_data_ok) begin
            if (r_sel == 8'h27 && !r_part) w_mode = 1'b1;
            if (r_sel == 8'h28 && !r_part) w_up[0] = 1'b1;
            // Channel index 3 does not exist in a part; those slots are holes.
            if (r_sel[1:0] != 2'b11) begin
                case (r_sel[7:4])
                    4'h3:    w_up[4]  = 1'b1;
                    4'h4:    w_up[5]  = 1'b1;
                    4'h5:    w_up[6]  = 1'b1;
                    4'h6:    w_up[7]  = 1'b1;
                    4'h7:    w_up[8]  = 1'b1;
                    4'h8:    w_up[9]  = 1'b1;
                    4'h9:    w_up[10] = 1'b1;
                    4'hA: begin
                        case (r_sel[3:2])
                            2'b00:   w_up[2] = 1'b1;
                            2'b01:   w_latch = 1'b1;
                            2'b10:   w_ch3lo = ~r_part;
                            default: w_ch3hi = ~r_part;
                        endcase
                    end
                    4'hB: begin
                        if (r_sel[3:2] == 2'b00) w_up[1] = 1'b1;
                        if (r_sel[3:2] == 2'b01) w_up[3] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= '0;
            r_part       <= 1'b0;
            r_cnt        <= '0;
            r_ch3_latch  <= '0;
            busy         <= 1'b0;
            din          <= '0;
            ch           <= '0;
            op           <= '0;
            up           <= '0;
            latch_fnum   <= '0;
            effect       <= 1'b0;
            csm          <= 1'b0;
            fnum_ch3op1  <= '0;
            fnum_ch3op2  <= '0;
            fnum_ch3op3  <= '0;
            block_ch3op1 <= '0;
            block_ch3op2 <= '0;
            block_ch3op3 <= '0;
        end else begin
            if (cpu_wr && !cpu_addr[0]) begin
                r_sel  <= cpu_din;
                r_part <= cpu_addr[1];
            end
            // Hold the request for one visit of every ring slot.
            if (|w_up) begin
                din   <= cpu_din;
                ch    <= {r_part, r_sel[1:0]};
                op    <= r_sel[3:2];
                up    <= w_up;
                busy  <= 1'b1;
                r_cnt <= '0;
            end else if (busy && clk_en) begin
                if (r_cnt == c_last) begin
                    up    <= '0;
                    busy  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end
            if (w_mode) begin
                effect <= |cpu_din[7:6];
                csm    <= (cpu_din[7:6] == 2'b10);
            end
            if (w_latch) latch_fnum  <= cpu_din[5:0];
            if (w_ch3hi) r_ch3_latch <= cpu_din[5:0];
            if (w_ch3lo) begin
                case (r_sel[1:0])
                    2'b01: begin
                        fnum_ch3op1  <= {r_ch3_latch[2:0], cpu_din};
                        block_ch3op1 <= r_ch3_latch[5:3];
                    end
                    2'b10: begin
                        fnum_ch3op2  <= {r_ch3_latch[2:0], cpu_din};
                        block_ch3op2 <= r_ch3_latch[5:3];
                    end
                    default: begin
                        fnum_ch3op3  <= {r_ch3_latch[2:0], cpu_din};
                        block_ch3op3 <= r_ch3_latch[5:3];
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
